// File: rtl/tile_map_sweeper_pkg.sv
// Shared tile codes, map geometry and FSM state type for the tile map sweeper.
package tile_map_sweeper_pkg;

  localparam int ADDR_W = 10;
  localparam int TILE_W = 4;

  localparam logic [TILE_W-1:0] TILE_EMPTY = 4'd0;
  localparam logic [TILE_W-1:0] TILE_WALL  = 4'd1;
  localparam logic [TILE_W-1:0] TILE_FOOD  = 4'd2;

  localparam int                MAP_TILES = 768;
  localparam logic [ADDR_W-1:0] LAST_ADDR = 10'h2FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } sweep_state_t;

  function automatic logic is_food(input logic [TILE_W-1:0] code);
    return (code == TILE_FOOD);
  endfunction

endpackage

// File: rtl/tile_map_sweeper_if.sv
// Game-logic tile write request handshake; the requester holds wr_req until wr_ack.
interface tile_map_sweeper_if;
  import tile_map_sweeper_pkg::*;

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [TILE_W-1:0] wr_data;
  logic              wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);

endinterface

// File: rtl/tile_map_sweeper_sweep_counter.sv
// Tile index counter for the sweep: clear has priority over enable, last flags the final tile.
module sweep_counter
  import tile_map_sweeper_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_W-1:0] count,
  output logic              last
);

  logic [ADDR_W-1:0] count_r;

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= 10'h000;
    end else if (clr) begin
      count_r <= 10'h000;
    end else if (en) begin
      count_r <= count_r + 10'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign last  = (count_r == LAST_ADDR);

endmodule

// File: rtl/tile_map_sweeper.sv
// Sweeps the 768-tile map through a shared single-port tile RAM, yielding the port to game writes.
module tile_map_sweeper
  import tile_map_sweeper_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  tile_map_sweeper_if.slave        wr_bus,
  output logic [ADDR_W-1:0]        ram_addr,
  input  logic [TILE_W-1:0]        ram_rd_data,
  output logic                     ram_wr_en,
  output logic [TILE_W-1:0]        ram_wr_data,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [TILE_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     sweep_done
);

  sweep_state_t      state_r;
  sweep_state_t      state_nxt_s;
  logic              pending_r;
  logic              pending_nxt_s;
  logic [ADDR_W-1:0] cnt_s;
  logic              cnt_last_s;
  logic              cnt_clr_s;
  logic              grant_s;
  logic              issue_s;
  logic [ADDR_W-1:0] out_addr_r;
  logic              out_valid_r;
  logic              busy_r;
  logic              sweep_done_r;

  sweep_counter u_sweep_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr_s),
    .en    (issue_s),
    .count (cnt_s),
    .last  (cnt_last_s)
  );

  // State and pending-start registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      pending_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
    end
  end

  // Next-state logic; a start that collides with a write waits one cycle as pending
  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    cnt_clr_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if ((start || pending_r) && !wr_bus.wr_req) begin
          state_nxt_s   = SCAN;
          pending_nxt_s = 1'b0;
          cnt_clr_s     = 1'b1;
        end else if (start) begin
          pending_nxt_s = 1'b1;
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      SCAN: begin
        if (issue_s && cnt_last_s) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = SCAN;
        end
      end
      FLUSH: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s   = IDLE;
        pending_nxt_s = 1'b0;
      end
    endcase
  end

  // RAM port arbitration: a write always wins, otherwise SCAN issues the counter address
  always_comb begin
    grant_s     = 1'b0;
    issue_s     = 1'b0;
    ram_addr    = 10'h000;
    ram_wr_en   = 1'b0;
    ram_wr_data = TILE_EMPTY;
    if (reset) begin
      grant_s = 1'b0;
    end else if (wr_bus.wr_req) begin
      grant_s     = 1'b1;
      ram_addr    = wr_bus.wr_addr;
      ram_wr_en   = 1'b1;
      ram_wr_data = wr_bus.wr_data;
    end else if (state_r == SCAN) begin
      issue_s  = 1'b1;
      ram_addr = cnt_s;
    end else begin
      issue_s = 1'b0;
    end
  end

  assign wr_bus.wr_ack = grant_s;

  // Output pipeline aligned with the one-cycle RAM read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      out_addr_r   <= 10'h000;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      sweep_done_r <= 1'b0;
    end else begin
      out_addr_r   <= issue_s ? cnt_s : 10'h000;
      out_valid_r  <= issue_s;
      busy_r       <= (state_nxt_s != IDLE);
      sweep_done_r <= (state_r == FLUSH);
    end
  end

  assign out_addr   = out_addr_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_valid_r ? ram_rd_data : TILE_EMPTY;
  assign busy       = busy_r;
  assign sweep_done = sweep_done_r;

endmodule

// File: tb/tb_tile_map_sweeper.sv
// Directed bench for tile_map_sweeper: RAM model, beat scoreboard and a bench-side food-count stage.
module tb_tile_map_sweeper;
  import tile_map_sweeper_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] ram_addr;
  logic [3:0] ram_rd_data;
  logic       ram_wr_en;
  logic [3:0] ram_wr_data;
  logic [9:0] out_addr;
  logic [3:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       sweep_done;

  tile_map_sweeper_if wr_bus();

  logic [3:0]  mem     [0:1023];
  logic [3:0]  ref_map [0:1023];
  logic [13:0] exp_q[$];
  logic [13:0] exp_e;
  logic [9:0]  food_list [0:4];

  int   n_checks = 0;
  int   n_fail = 0;
  int   beats = 0;
  int   done_cnt = 0;
  int   food_cnt = 0;
  int   latched_food = 0;
  logic game_over = 1'b0;

  tile_map_sweeper dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .wr_bus      (wr_bus),
    .ram_addr    (ram_addr),
    .ram_rd_data (ram_rd_data),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_data (ram_wr_data),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .busy        (busy),
    .sweep_done  (sweep_done)
  );

  always #5 clk = ~clk;

  // Synchronous tile RAM, read data one cycle after the address
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard and food-count stage, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        chk("beat_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          chk("beat_addr", 32'(out_addr), 32'(exp_e[13:4]));
          chk("beat_data", 32'(out_data), 32'(exp_e[3:0]));
        end
        beats++;
        if (is_food(out_data)) food_cnt++;
      end
      if (sweep_done) begin
        done_cnt++;
        latched_food = food_cnt;
        game_over    = (food_cnt == 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm_sweep();
    exp_q.delete();
    beats    = 0;
    food_cnt = 0;
    for (int a = 0; a < MAP_TILES; a++) exp_q.push_back({10'(a), ref_map[a]});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (!sweep_done && k < limit) begin
      tick(1);
      k++;
    end
    chk("done_seen", 32'(sweep_done), 32'd1);
    tick(1);
  endtask

  task automatic check_sweep(input string tag, input int exp_done);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(exp_done));
    chk({tag, "_beats"}, 32'(beats), 32'(MAP_TILES));
    chk({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic fill_map(input int pattern);
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = (pattern == 0) ? 4'(i) : ~4'(i);
      ref_map[i] = mem[i];
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_wr_en"}, 32'(ram_wr_en), 32'd0);
    chk({tag, "_ram_wr_data"}, 32'(ram_wr_data), 32'd0);
    chk({tag, "_wr_ack"}, 32'(wr_bus.wr_ack), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_addr"}, 32'(out_addr), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_sweep_done"}, 32'(sweep_done), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    wr_bus.wr_req  = 1'b0;
    wr_bus.wr_addr = 10'h000;
    wr_bus.wr_data = 4'd0;
    food_list[0] = 10'h000;
    food_list[1] = 10'h0FF;
    food_list[2] = 10'h1A3;
    food_list[3] = 10'h2FE;
    food_list[4] = 10'h2FF;
    fill_map(0);
    tick(3);
    check_all_zero("reset");
    reset = 1'b0;
    tick(1);

    // Plain sweep with data = addr[3:0], exact latency and end timing
    arm_sweep();
    pulse_start();
    chk("t1_busy_c1", 32'(busy), 32'd1);
    chk("t1_valid_c1", 32'(out_valid), 32'd0);
    tick(1);
    chk("t1_first_valid", 32'(out_valid), 32'd1);
    chk("t1_first_addr", 32'(out_addr), 32'h000);
    tick(767);
    chk("t1_last_valid", 32'(out_valid), 32'd1);
    chk("t1_last_addr", 32'(out_addr), 32'h2FF);
    chk("t1_last_data", 32'(out_data), 32'hF);
    chk("t1_flush_busy", 32'(busy), 32'd1);
    chk("t1_flush_done", 32'(sweep_done), 32'd0);
    tick(1);
    chk("t1_done_pulse", 32'(sweep_done), 32'd1);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_valid", 32'(out_valid), 32'd0);
    tick(1);
    chk("t1_done_drop", 32'(sweep_done), 32'd0);
    check_sweep("t1", 1);

    // Write at 0x010 while the counter sits at 0x100
    arm_sweep();
    pulse_start();
    tick(256);
    chk("t2_pre_addr", 32'(ram_addr), 32'h100);
    wr_bus.wr_req  = 1'b1;
    wr_bus.wr_addr = 10'h010;
    wr_bus.wr_data = TILE_EMPTY;
    ref_map[10'h010] = TILE_EMPTY;
    #1;
    chk("t2_wr_ack", 32'(wr_bus.wr_ack), 32'd1);
    chk("t2_wr_en", 32'(ram_wr_en), 32'd1);
    chk("t2_wr_addr", 32'(ram_addr), 32'h010);
    tick(1);
    wr_bus.wr_req = 1'b0;
    #1;
    chk("t2_ack_drop", 32'(wr_bus.wr_ack), 32'd0);
    chk("t2_held_addr", 32'(ram_addr), 32'h100);
    chk("t2_gap_valid", 32'(out_valid), 32'd0);
    chk("t2_gap_data", 32'(out_data), 32'd0);
    tick(1);
    chk("t2_resume_addr", 32'(out_addr), 32'h100);
    wait_done(1000);
    check_sweep("t2", 2);

    // Food counting, then clear all food with back-to-back writes
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = ((i % 7) == 3) ? TILE_WALL : TILE_EMPTY;
      ref_map[i] = mem[i];
    end
    for (int i = 0; i < 5; i++) begin
      mem[food_list[i]]     = TILE_FOOD;
      ref_map[food_list[i]] = TILE_FOOD;
    end
    arm_sweep();
    pulse_start();
    wait_done(1000);
    check_sweep("t3", 3);
    chk("t3_food_count", 32'(latched_food), 32'd5);
    chk("t3_not_over", 32'(game_over), 32'd0);
    wr_bus.wr_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_bus.wr_addr = food_list[i];
      wr_bus.wr_data = TILE_EMPTY;
      ref_map[food_list[i]] = TILE_EMPTY;
      #1;
      chk("t3_b2b_ack", 32'(wr_bus.wr_ack), 32'd1);
      chk("t3_b2b_addr", 32'(ram_addr), 32'(food_list[i]));
      tick(1);
    end
    wr_bus.wr_req = 1'b0;
    arm_sweep();
    pulse_start();
    wait_done(1000);
    check_sweep("t3b", 4);
    chk("t3b_food_count", 32'(latched_food), 32'd0);
    chk("t3b_game_over", 32'(game_over), 32'd1);

    // Start reissued mid-sweep is ignored
    fill_map(0);
    arm_sweep();
    pulse_start();
    tick(10'h050);
    chk("t4_addr_050", 32'(ram_addr), 32'h050);
    pulse_start();
    wait_done(1000);
    check_sweep("t4", 5);
    tick(5);
    chk("t4_single_done", 32'(done_cnt), 32'd5);

    // Reset at counter 0x1A0 aborts the sweep silently
    fill_map(1);
    arm_sweep();
    pulse_start();
    tick(10'h1A0);
    chk("t5_addr_1a0", 32'(ram_addr), 32'h1A0);
    reset = 1'b1;
    tick(1);
    check_all_zero("t5_abort");
    reset = 1'b0;
    tick(3);
    chk("t5_no_done", 32'(done_cnt), 32'd5);
    arm_sweep();
    pulse_start();
    wait_done(1000);
    check_sweep("t5", 6);

    // Start and write in the same idle cycle
    ref_map[10'h2FE] = TILE_FOOD;
    arm_sweep();
    start          = 1'b1;
    wr_bus.wr_req  = 1'b1;
    wr_bus.wr_addr = 10'h2FE;
    wr_bus.wr_data = TILE_FOOD;
    #1;
    chk("t6_wr_ack", 32'(wr_bus.wr_ack), 32'd1);
    chk("t6_wr_en", 32'(ram_wr_en), 32'd1);
    chk("t6_wr_data", 32'(ram_wr_data), 32'(TILE_FOOD));
    chk("t6_wr_addr", 32'(ram_addr), 32'h2FE);
    tick(1);
    start         = 1'b0;
    wr_bus.wr_req = 1'b0;
    wait_done(1000);
    check_sweep("t6", 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_map_sweeper.md
TILE_MAP_SWEEPER -- requirements
Module: tile_map_sweeper

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1, request one full map sweep (single-cycle pulse).
REQ-004 SHALL have port wr_req, input, 1, game logic requests a tile write; held until wr_ack.
REQ-005 SHALL have port wr_addr, input, 10, tile index to write.
REQ-006 SHALL have port wr_data, input, 4, tile code to write (0 empty, 1 wall, 2 food).
REQ-007 SHALL have port wr_ack, output, 1, one-cycle pulse in the cycle the write is issued.
REQ-008 SHALL have port ram_addr, output, 10, tile RAM address (shared read/write).
REQ-009 SHALL have port ram_rd_data, input, 4, tile RAM read data, valid 1 cycle after ram_addr.
REQ-010 SHALL have ports ram_wr_en (output, 1) and ram_wr_data (output, 4), the tile RAM write strobe and data.
REQ-011 SHALL have ports out_addr (output, 10) and out_data (output, 4), the address/data pair feeding the food-count stage.
REQ-012 SHALL have ports out_valid (output, 1, out_addr/out_data hold a swept tile), busy (output, 1, sweep in progress) and sweep_done (output, 1, one-cycle pulse after the last tile is presented).

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, FLUSH.
REQ-014 IDLE: start (or pending start) -> SCAN with sweep counter = 0x000.
REQ-015 SCAN: each non-write cycle, ram_addr = counter, counter += 1; after issuing 0x2FF -> FLUSH.
REQ-016 FLUSH: one cycle to present the 0x2FF data, assert sweep_done, then -> IDLE.
REQ-017 out_addr/out_data/out_valid SHALL be registered one cycle after the read address is issued, so out_addr always equals the address whose data is in out_data.
REQ-018 When out_valid = 0, out_data SHALL be forced to 0 and out_addr to 0x000, so downstream never counts stale food.
REQ-019 Sweep SHALL cover exactly 768 tiles, 0x000..0x2FF, in ascending order, including 0x2FE and 0x2FF, with no repeats or gaps.
REQ-020 A pending wr_req SHALL win the RAM port in any state; in that cycle ram_wr_en = 1, ram_addr = wr_addr, wr_ack = 1, the sweep counter holds, and the next out_valid = 0.
REQ-021 Back-to-back wr_req SHALL be granted one per cycle; the sweep resumes from the held counter value with no tile skipped.
REQ-022 A start received while busy SHALL be ignored.
REQ-023 A start coinciding with wr_req in IDLE SHALL be latched as pending; the write is served first and the sweep begins the next cycle.
REQ-024 busy SHALL be 1 in SCAN and FLUSH, and 0 in IDLE.
REQ-025 ram_wr_data SHALL equal wr_data when ram_wr_en = 1, and 0 otherwise.

Reset
REQ-026 Reset SHALL force IDLE, clear the counter and pending start, and drive all outputs to 0 (ram_addr 0x000, out_valid 0, busy 0, sweep_done 0, wr_ack 0, ram_wr_en 0).
REQ-027 Reset mid-sweep SHALL abort without a sweep_done pulse; the next start restarts at 0x000.

Structure
REQ-028 A shared package SHALL hold the tile code constants (TILE_EMPTY=0, TILE_WALL=1, TILE_FOOD=2), MAP_TILES=768, LAST_ADDR=0x2FF and the FSM state enum.
REQ-029 A single sub-module, sweep_counter (10-bit counter with clear, enable and terminal flag), is permitted; everything else SHALL be flat.

Verification
REQ-030 RAM model with data = addr[3:0]; pulse start -> out_addr 0x000..0x2FF consecutively, first out_valid 2 cycles after start, sweep_done once, busy 0 after 770 cycles.
REQ-031 wr_req at addr 0x010, data 0, asserted when counter = 0x100 -> wr_ack 1 cycle, one out_valid gap, no address skipped, total 768 valid beats.
REQ-032 Map preloaded with 5 food tiles; sweep into the food-count stage -> count = 5 latched at the sweep end; the next sweep after clearing all 5 via writes -> game_over = 1.
REQ-033 Start reissued during SCAN at counter 0x050 -> ignored; exactly one sweep_done.
REQ-034 Reset asserted at counter 0x1A0 -> all outputs 0 the next cycle, no sweep_done; a fresh start sweeps from 0x000.
REQ-035 start and wr_req in the same IDLE cycle -> write first (wr_ack), sweep starts the next cycle, with out_addr 0x000 first.
